// File: rtl/ehr_2.sv
// Two-port ephemeral history register: port 0 reads the start-of-cycle value,
// port 1 sees port 0's write forwarded; the last enabled write commits.
module ehr_2 #(
    parameter int unsigned N    = 32,
    parameter logic [N-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] wd0,
    input  logic         wv0,
    input  logic [N-1:0] wd1,
    input  logic         wv1,
    output logic [N-1:0] r0,
    output logic [N-1:0] r1
);

    logic [N-1:0] q;
    logic [N-1:0] q_nxt;

    // Port 1 is ordered after port 0, so its write takes priority at commit.
    assign q_nxt = wv1 ? wd1 : (wv0 ? wd0 : q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= INIT;
        end else begin
            q <= q_nxt;
        end
    end

    assign r0 = q;
    assign r1 = wv0 ? wd0 : q;

endmodule

// File: tb/tb_ehr_2.sv
// Directed-vector bench for ehr_2: reset, forwarding, port priority,
// back-to-back writes, hold, and mid-stream reset release.
module tb_ehr_2;

    localparam int unsigned N = 32;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] wd0;
    logic         wv0;
    logic [N-1:0] wd1;
    logic         wv1;
    logic [N-1:0] r0;
    logic [N-1:0] r1;

    int unsigned n_vec;
    int unsigned n_miss;

    ehr_2 #(.N(N), .INIT('0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wd0  (wd0),
        .wv0  (wv0),
        .wd1  (wd1),
        .wv1  (wv1),
        .r0   (r0),
        .r1   (r1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] cnt;
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        wv0    = 1'b0;
        wv1    = 1'b0;
        wd0    = '0;
        wd1    = '0;

        // Reset held for four edges
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reset_r0", r0, 32'h0);
            check("reset_r1", r1, 32'h0);
        end

        // Reset dominates both writes; r1 still forwards
        wv0 = 1'b1; wd0 = 32'h5;
        wv1 = 1'b1; wd1 = 32'h6;
        #1;
        check("rstpri_r1", r1, 32'h5);
        tick();
        check("rstpri_r0", r0, 32'h0);
        wv0 = 1'b0; wv1 = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rstpri_r1_idle", r1, 32'h0);

        // Port-0 only
        wv0 = 1'b1; wd0 = 32'h11;
        #1;
        check("p0_r1_same", r1, 32'h11);
        check("p0_r0_same", r0, 32'h0);
        tick();
        wv0 = 1'b0; wd0 = 32'hDEAD_BEEF;
        #1;
        check("p0_r0_next", r0, 32'h11);
        check("p0_r1_next", r1, 32'h11);

        // Port-1 only: invisible within its own cycle
        wv1 = 1'b1; wd1 = 32'h22;
        #1;
        check("p1_r0_same", r0, 32'h11);
        check("p1_r1_same", r1, 32'h11);
        tick();
        wv1 = 1'b0;
        #1;
        check("p1_r0_next", r0, 32'h22);

        // Both ports every cycle: r1 shows wd0, port 1 commits
        for (int i = 0; i < 8; i++) begin
            cnt = N'(i);
            wd0 = cnt; wd1 = ~cnt;
            wv0 = 1'b1; wv1 = 1'b1;
            #1;
            check("both_r1", r1, cnt);
            if (i == 0) check("both_r0_first", r0, 32'h22);
            else        check("both_r0", r0, ~(cnt - 32'h1));
            tick();
        end
        wv0 = 1'b0; wv1 = 1'b0;
        #1;
        check("both_r0_last", r0, 32'hFFFF_FFF8);

        // Hold with garbage data on invalid ports
        for (int i = 0; i < 5; i++) begin
            wd0 = $urandom;
            wd1 = $urandom;
            #1;
            check("hold_r0", r0, 32'hFFFF_FFF8);
            check("hold_r1", r1, 32'hFFFF_FFF8);
            tick();
        end

        // Mid-stream reset, then release with a write on the first live edge
        rst_n = 1'b0;
        tick();
        check("midrst_r0", r0, 32'h0);
        rst_n = 1'b1;
        wv1 = 1'b1; wd1 = 32'hAB;
        wv0 = 1'b1; wd0 = 32'hCD;
        #1;
        check("release_r1", r1, 32'hCD);
        tick();
        wv0 = 1'b0; wv1 = 1'b0;
        #1;
        check("release_r0", r0, 32'hAB);

        // Port-0 write alone commits when port 1 is idle
        wv0 = 1'b1; wd0 = 32'h1234_5678;
        tick();
        wv0 = 1'b0;
        #1;
        check("p0_commit_r0", r0, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
